pe_ins_dispatch: RTL and testbench

- Instruction front end for a parametrised PE array; the successor to the fixed "ins_ready = 1" instruction receive logic.
- Queues incoming PE instructions in a FIFO and decodes the target PE or PE group, with group size as a parameter.
- Tracks per-PE busy state from done pulses and holds an instruction until all of its target PEs are free, then issues a one-cycle start mask plus registered instruction fields.
- Back-pressure via ins_ready replaces the always-ready behaviour.

---
 rtl/pe_ins_dispatch.sv | 160 ++++++++++++++++
 tb/tb_pe_ins_dispatch.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_ins_dispatch.sv
// PE instruction dispatcher: FIFO-buffered, busy-aware, in-order issue
// of start masks to single PEs or PE groups.
module pe_ins_dispatch #(
    parameter int PE_NUM     = 32,
    parameter int GRP_SIZE   = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int INST_W     = 64,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        layer_type,
    input  logic [INST_W-1:0] ins,
    input  logic              ins_valid,
    output logic              ins_ready,
    input  logic [PE_NUM-1:0] done,
    output logic [PE_NUM-1:0] start,
    output logic [7:0]        idx_cnt,
    output logic [7:0]        trip_cnt,
    output logic [3:0]        pad_code,
    output logic              is_new,
    output logic              cut_y,
    output logic [PE_NUM-1:0] busy,
    output logic              idle,
    output logic              err_oob,
    output logic [CNT_W-1:0]  issue_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = 29;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [PE_NUM-1:0] GRP_MASK =
        PE_NUM'((64'd1 << GRP_SIZE) - 64'd1);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t            state_q, state_d;
    logic [EW-1:0]     mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       cnt_q, cnt_d;
    logic              rdy_q;
    logic [EW-1:0]     hold_q;
    logic [PE_NUM-1:0] busy_q, start_q, mask, busy_clr;
    logic [7:0]        idx_q, trip_q;
    logic [3:0]        pad_q;
    logic              new_q, cut_q, err_q;
    logic [CNT_W-1:0]  icnt_q;
    logic              push, pop, issue, drop, oob;
    logic [31:0]       pe_w;
    logic              unused_ok;

    assign unused_ok = ^{layer_type[3:1], ins[INST_W-1:60], ins[31:0]};

    assign push     = ins_valid && rdy_q;
    assign cnt_d    = cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    assign busy_clr = busy_q & ~done;

    // Target mask and range check of the held instruction
    always_comb begin
        pe_w = 32'(hold_q[25:20]);
        mask = '0;
        oob  = 1'b0;
        if (hold_q[28]) begin
            mask = PE_NUM'(1) << pe_w;
            oob  = pe_w >= 32'(PE_NUM);
        end else begin
            mask = GRP_MASK << (pe_w * 32'(GRP_SIZE));
            oob  = pe_w >= 32'(PE_NUM / GRP_SIZE);
        end
    end

    // Next-state: pop into hold, then issue or drop once targets are free
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        issue   = 1'b0;
        drop    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (cnt_q != '0) begin
                    pop     = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (oob) begin
                    drop    = 1'b1;
                    state_d = S_IDLE;
                end else if ((busy_clr & mask) == '0) begin
                    issue   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // FIFO storage, written on accepted instructions
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {layer_type[0], ins[59:32]};
    end

    // FIFO pointers, hold register, busy tracking and issued fields
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            rdy_q    <= 1'b0;
            hold_q   <= '0;
            busy_q   <= '0;
            start_q  <= '0;
            idx_q    <= '0;
            trip_q   <= '0;
            pad_q    <= '0;
            new_q    <= 1'b0;
            cut_q    <= 1'b0;
            err_q    <= 1'b0;
            icnt_q   <= '0;
        end else begin
            cnt_q   <= cnt_d;
            rdy_q   <= cnt_d != FULL_CNT;
            start_q <= issue ? mask : '0;
            busy_q  <= busy_clr | (issue ? mask : '0);
            err_q   <= drop;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) begin
                hold_q   <= mem_q[rd_ptr_q];
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (issue) begin
                idx_q  <= hold_q[7:0];
                trip_q <= hold_q[15:8];
                pad_q  <= hold_q[19:16];
                new_q  <= hold_q[26];
                cut_q  <= hold_q[27];
                icnt_q <= icnt_q + 1'b1;
            end
        end
    end

    assign ins_ready = rdy_q;
    assign start     = start_q;
    assign idx_cnt   = idx_q;
    assign trip_cnt  = trip_q;
    assign pad_code  = pad_q;
    assign is_new    = new_q;
    assign cut_y     = cut_q;
    assign busy      = busy_q;
    assign idle      = (cnt_q == '0) && (state_q == S_IDLE) && (busy_q == '0);
    assign err_oob   = err_q;
    assign issue_cnt = icnt_q;

endmodule

// File: tb/tb_pe_ins_dispatch.sv
// Directed bench for pe_ins_dispatch: issue latency, group masks,
// range drops, back-pressure, same-edge done/start and reset flush.
module tb_pe_ins_dispatch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  layer_type = '0;
    logic [63:0] ins = '0;
    logic        ins_valid = 1'b0;
    logic        ins_ready;
    logic [31:0] done = '0;
    logic [31:0] start;
    logic [7:0]  idx_cnt, trip_cnt;
    logic [3:0]  pad_code;
    logic        is_new, cut_y;
    logic [31:0] busy;
    logic        idle, err_oob;
    logic [15:0] issue_cnt;

    int compared = 0;
    int failed   = 0;

    pe_ins_dispatch dut (
        .clk(clk), .rst(rst), .layer_type(layer_type), .ins(ins),
        .ins_valid(ins_valid), .ins_ready(ins_ready), .done(done),
        .start(start), .idx_cnt(idx_cnt), .trip_cnt(trip_cnt),
        .pad_code(pad_code), .is_new(is_new), .cut_y(cut_y),
        .busy(busy), .idle(idle), .err_oob(err_oob),
        .issue_cnt(issue_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ins(input logic mode, input logic [5:0] pe,
                           input logic [7:0] idx);
        layer_type     = {3'b000, mode};
        ins            = '0;
        ins[39:32]     = idx;
        ins[47:40]     = ~idx;
        ins[51:48]     = idx[3:0];
        ins[57:52]     = pe;
        ins[58]        = idx[0];
        ins[59]        = idx[1];
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        compared++;
        if (start !== 32'h0 || busy !== 32'h0 || issue_cnt !== 16'h0 ||
            err_oob !== 1'b0 || ins_ready !== 1'b0) begin
            failed++;
            $display("FAIL reset_outs: start=%h busy=%h cnt=%h err=%b rdy=%b want all 0",
                     start, busy, issue_cnt, err_oob, ins_ready);
        end
        compared++;
        if (idle !== 1'b1) begin
            failed++;
            $display("FAIL reset_idle: got %b want 1", idle);
        end
        rst = 1'b0;
        tick();
        compared++;
        if (ins_ready !== 1'b1) begin
            failed++;
            $display("FAIL reset_ready: got %b want 1", ins_ready);
        end
    endtask

    task automatic test_single();
        set_ins(1'b1, 6'd5, 8'h12);
        ins_valid = 1'b1;
        tick();
        ins_valid = 1'b0;
        tick();
        compared++;
        if (start !== 32'h0) begin
            failed++;
            $display("FAIL single_early: start=%h want 0", start);
        end
        tick();
        compared++;
        if (start !== 32'h0000_0020 || idx_cnt !== 8'h12 || busy !== 32'h20 ||
            issue_cnt !== 16'd1 || idle !== 1'b0) begin
            failed++;
            $display("FAIL single_issue: start=%h idx=%h busy=%h cnt=%0d idle=%b want 20/12/20/1/0",
                     start, idx_cnt, busy, issue_cnt, idle);
        end
        compared++;
        if (trip_cnt !== 8'hED || pad_code !== 4'h2 || is_new !== 1'b0 ||
            cut_y !== 1'b1) begin
            failed++;
            $display("FAIL single_fields: trip=%h pad=%h new=%b cut=%b want ed/2/0/1",
                     trip_cnt, pad_code, is_new, cut_y);
        end
        tick();
        compared++;
        if (start !== 32'h0 || idx_cnt !== 8'h12) begin
            failed++;
            $display("FAIL single_pulse: start=%h idx=%h want 0/12", start, idx_cnt);
        end
        done = 32'h20;
        tick();
        done = '0;
        compared++;
        if (busy !== 32'h0 || idle !== 1'b1) begin
            failed++;
            $display("FAIL single_release: busy=%h idle=%b want 0/1", busy, idle);
        end
    endtask

    task automatic test_group();
        set_ins(1'b0, 6'd2, 8'h21);
        ins_valid = 1'b1;
        tick();
        ins_valid = 1'b0;
        tick();
        tick();
        compared++;
        if (start !== 32'h0000_0F00 || busy !== 32'h0000_0F00) begin
            failed++;
            $display("FAIL group_issue: start=%h busy=%h want f00/f00", start, busy);
        end
        set_ins(1'b0, 6'd2, 8'h22);
        ins_valid = 1'b1;
        tick();
        ins_valid = 1'b0;
        tick();
        tick();
        compared++;
        if (start !== 32'h0) begin
            failed++;
            $display("FAIL group_blocked: start=%h want 0", start);
        end
        done = 32'h200;
        tick();
        done = '0;
        compared++;
        if (start !== 32'h0 || busy !== 32'h0000_0D00) begin
            failed++;
            $display("FAIL group_partial: start=%h busy=%h want 0/d00", start, busy);
        end
        tick();
        done = 32'h0000_0D00;
        tick();
        done = '0;
        compared++;
        if (start !== 32'h0000_0F00 || idx_cnt !== 8'h22 ||
            busy !== 32'h0000_0F00 || issue_cnt !== 16'd3) begin
            failed++;
            $display("FAIL group_reissue: start=%h idx=%h busy=%h cnt=%0d want f00/22/f00/3",
                     start, idx_cnt, busy, issue_cnt);
        end
        done = 32'h0000_0F00;
        tick();
        done = '0;
        tick();
    endtask

    task automatic test_oob();
        int errs;
        int starts;
        for (int m = 0; m < 2; m++) begin
            if (m == 0) set_ins(1'b1, 6'd40, 8'h33);
            else        set_ins(1'b0, 6'd8, 8'h34);
            ins_valid = 1'b1;
            tick();
            ins_valid = 1'b0;
            errs   = 0;
            starts = 0;
            for (int c = 0; c < 5; c++) begin
                tick();
                if (err_oob === 1'b1) errs++;
                if (start !== 32'h0) starts++;
            end
            compared++;
            if (errs != 1 || starts != 0 || issue_cnt !== 16'd3) begin
                failed++;
                $display("FAIL oob_mode%0d: err_pulses=%0d starts=%0d cnt=%0d want 1/0/3",
                         m, errs, starts, issue_cnt);
            end
        end
    endtask

    task automatic test_backpressure();
        int  sent;
        int  n;
        logic acc;
        set_ins(1'b1, 6'd0, 8'h30);
        ins_valid = 1'b1;
        tick();
        ins_valid = 1'b0;
        tick();
        tick();
        compared++;
        if (start !== 32'h1 || busy !== 32'h1) begin
            failed++;
            $display("FAIL bp_first: start=%h busy=%h want 1/1", start, busy);
        end
        sent = 0;
        set_ins(1'b1, 6'd0, 8'h40);
        ins_valid = 1'b1;
        for (int c = 0; c < 14; c++) begin
            acc = ins_valid && ins_ready;
            tick();
            if (acc) begin
                sent++;
                set_ins(1'b1, 6'd0, 8'(8'h40 + sent));
            end
        end
        compared++;
        if (sent != 9 || ins_ready !== 1'b0) begin
            failed++;
            $display("FAIL bp_full: accepted=%0d ready=%b want 9/0", sent, ins_ready);
        end
        n = 0;
        done = 32'h1;
        for (int c = 0; c < 200 && n < 10; c++) begin
            acc = ins_valid && ins_ready;
            tick();
            done = '0;
            if (acc) begin
                sent++;
                if (sent == 10) ins_valid = 1'b0;
                else set_ins(1'b1, 6'd0, 8'(8'h40 + sent));
            end
            if (start[0] === 1'b1) begin
                compared++;
                if (idx_cnt !== 8'(8'h40 + n)) begin
                    failed++;
                    $display("FAIL bp_order%0d: idx=%h want %h", n, idx_cnt, 8'(8'h40 + n));
                end
                n++;
                done = 32'h1;
            end
        end
        ins_valid = 1'b0;
        compared++;
        if (n != 10 || sent != 10 || issue_cnt !== 16'd14) begin
            failed++;
            $display("FAIL bp_drain: issued=%0d sent=%0d cnt=%0d want 10/10/14",
                     n, sent, issue_cnt);
        end
        tick();
        done = '0;
        tick();
        compared++;
        if (busy !== 32'h0 || idle !== 1'b1) begin
            failed++;
            $display("FAIL bp_idle: busy=%h idle=%b want 0/1", busy, idle);
        end
    endtask

    task automatic test_same_edge();
        set_ins(1'b1, 6'd3, 8'h50);
        ins_valid = 1'b1;
        tick();
        set_ins(1'b1, 6'd3, 8'h51);
        tick();
        ins_valid = 1'b0;
        tick();
        compared++;
        if (start !== 32'h8 || idx_cnt !== 8'h50) begin
            failed++;
            $display("FAIL same_first: start=%h idx=%h want 8/50", start, idx_cnt);
        end
        tick();
        compared++;
        if (start !== 32'h0 || busy !== 32'h8) begin
            failed++;
            $display("FAIL same_wait: start=%h busy=%h want 0/8", start, busy);
        end
        done = 32'h8;
        tick();
        done = '0;
        compared++;
        if (start !== 32'h8 || busy !== 32'h8 || idx_cnt !== 8'h51 ||
            issue_cnt !== 16'd16) begin
            failed++;
            $display("FAIL same_edge: start=%h busy=%h idx=%h cnt=%0d want 8/8/51/16",
                     start, busy, idx_cnt, issue_cnt);
        end
        done = 32'h8;
        tick();
        done = '0;
        tick();
    endtask

    task automatic test_reset_flush();
        int starts;
        set_ins(1'b1, 6'd7, 8'h60);
        ins_valid = 1'b1;
        tick();
        ins_valid = 1'b0;
        tick();
        tick();
        compared++;
        if (start !== 32'h80 || busy !== 32'h80) begin
            failed++;
            $display("FAIL flush_pre: start=%h busy=%h want 80/80", start, busy);
        end
        ins_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_ins(1'b1, 6'd7, 8'(8'h61 + k));
            tick();
        end
        ins_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        compared++;
        if (busy !== 32'h0 || start !== 32'h0 || idle !== 1'b1 ||
            issue_cnt !== 16'h0) begin
            failed++;
            $display("FAIL flush_state: busy=%h start=%h idle=%b cnt=%0d want 0/0/1/0",
                     busy, start, idle, issue_cnt);
        end
        tick();
        compared++;
        if (ins_ready !== 1'b1) begin
            failed++;
            $display("FAIL flush_ready: got %b want 1", ins_ready);
        end
        starts = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (start !== 32'h0) starts++;
        end
        compared++;
        if (starts != 0 || idle !== 1'b1) begin
            failed++;
            $display("FAIL flush_quiet: starts=%0d idle=%b want 0/1", starts, idle);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_group();
        test_oob();
        test_backpressure();
        test_same_edge();
        test_reset_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
